// File: rtl/user_io_evq_if.sv
`default_nettype none
// ============================================================================
// user_io_evq_if : event FIFO handshake between user_io_evq and its consumers
// Revision 1.0
// ============================================================================

interface user_io_evq_if;
  logic       EVT_VALID;
  logic       EVT_READY;
  logic [1:0] EVT_TYPE;
  logic [7:0] EVT_DATA;
  logic       EVT_OVERFLOW;

  modport master (
    output EVT_VALID, EVT_TYPE, EVT_DATA, EVT_OVERFLOW,
    input  EVT_READY
  );

  modport slave (
    input  EVT_VALID, EVT_TYPE, EVT_DATA, EVT_OVERFLOW,
    output EVT_READY
  );
endinterface

`default_nettype wire

// File: rtl/user_io_evq.sv
`default_nettype none
// ============================================================================
// user_io_evq : MiST user-IO SPI command receiver with joystick/button state
//               and a show-ahead mouse/keyboard/OSD event FIFO
// Revision 1.0
// ============================================================================

module user_io_evq #(
  parameter int NJOY        = 2,
  parameter int JOY_BYTES   = 1,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        SPI_CLK,
  input  logic                        SPI_SS_IO,
  input  logic                        SPI_MOSI,
  output logic                        SPI_MISO,
  input  logic [7:0]                  CORE_TYPE,
  output logic [NJOY*8*JOY_BYTES-1:0] JOY,
  output logic [1:0]                  BUTTONS,
  output logic [1:0]                  SWITCHES,
  output logic [3:0]                  CONF,
  output logic [2:0]                  MOUSE_BUTTONS,
  user_io_evq_if.master               evt
);

  localparam int              c_JW    = 8 * JOY_BYTES;
  localparam int              c_AW    = $clog2(FIFO_DEPTH);
  localparam int              c_CW    = c_AW + 1;
  localparam logic [2:0]      c_NJOY  = 3'(NJOY);
  localparam logic [4:0]      c_JB    = 5'(JOY_BYTES);
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);
  localparam logic [7:0]      c_CMD_BUT    = 8'h01;
  localparam logic [7:0]      c_CMD_MOUSE  = 8'h04;
  localparam logic [7:0]      c_CMD_KEY    = 8'h05;
  localparam logic [7:0]      c_CMD_OSD    = 8'h06;
  localparam logic [7:0]      c_CMD_STATUS = 8'h07;

  logic [SYNC_STAGES-1:0] r_clk_s, r_ss_s, r_mosi_s;
  logic                   r_sclk_d, r_ss_d, r_armed, r_miso, r_ovf;
  logic [7:0]             r_bitcnt, r_cmd, r_but_sw;
  logic [6:0]             r_sr;
  logic [2:0]             r_mb;
  logic [c_JW-1:0]        r_stage, w_joy_new;
  logic [NJOY*c_JW-1:0]   r_joy;
  logic [9:0]             r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]        r_wp, r_rp;
  logic [c_CW-1:0]        r_cnt;

  logic       w_sclk, w_ss, w_mosi, w_rise, w_fall, w_ss_rise, w_active;
  logic       w_shift, w_bdone, w_miso_bit, w_joy_hit, w_joy_ok;
  logic       w_push, w_pop, w_full, w_wr, w_ovf_set, w_ovf_clr, w_valid;
  logic [7:0] w_byte, w_status;
  logic [4:0] w_bidx;
  logic [1:0] w_joy_idx;
  logic [9:0] w_push_data;

  assign w_sclk    = r_clk_s[SYNC_STAGES-1];
  assign w_ss      = r_ss_s[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_s[SYNC_STAGES-1];
  assign w_rise    = w_sclk & ~r_sclk_d;
  assign w_fall    = ~w_sclk & r_sclk_d;
  assign w_ss_rise = w_ss & ~r_ss_d;
  // A frame only counts once SS has been seen high since reset.
  assign w_active  = r_armed & ~w_ss;
  assign w_shift   = w_active & w_rise;
  assign w_byte    = {r_sr, w_mosi};
  assign w_bdone   = w_shift & (r_bitcnt[2:0] == 3'd7);
  assign w_bidx    = r_bitcnt[7:3];
  assign w_status  = {r_ovf, 2'b00, 5'(r_cnt)};

  always_comb begin
    w_miso_bit = 1'b0;
    if (r_bitcnt[7:3] == 5'd0)
      w_miso_bit = CORE_TYPE[3'd7 - r_bitcnt[2:0]];
    else if (r_bitcnt[7:3] == 5'd1 && r_cmd == c_CMD_STATUS)
      w_miso_bit = w_status[3'd7 - r_bitcnt[2:0]];
  end

  always_comb begin
    w_joy_hit   = 1'b1;
    w_joy_idx   = 2'd0;
    w_push      = 1'b0;
    w_push_data = 10'd0;
    case (r_cmd)
      8'h02:   w_joy_idx = 2'd0;
      8'h03:   w_joy_idx = 2'd1;
      8'h10:   w_joy_idx = 2'd2;
      8'h11:   w_joy_idx = 2'd3;
      default: w_joy_hit = 1'b0;
    endcase
    if (w_bdone) begin
      if (r_cmd == c_CMD_MOUSE && w_bidx == 5'd1) begin
        w_push = 1'b1; w_push_data = {2'd0, w_byte};
      end else if (r_cmd == c_CMD_MOUSE && w_bidx == 5'd2) begin
        w_push = 1'b1; w_push_data = {2'd1, w_byte};
      end else if (r_cmd == c_CMD_KEY && w_bidx == 5'd1) begin
        w_push = 1'b1; w_push_data = {2'd2, w_byte};
      end else if (r_cmd == c_CMD_OSD && w_bidx == 5'd1) begin
        w_push = 1'b1; w_push_data = {2'd3, w_byte};
      end
    end
  end

  assign w_joy_ok = w_joy_hit & ({1'b0, w_joy_idx} < c_NJOY);

  always_comb begin
    w_joy_new = r_stage;
    w_joy_new[c_JW-1 -: 8] = w_byte;
  end

  assign w_valid   = (r_cnt != '0);
  assign w_full    = (r_cnt == c_DEPTH);
  assign w_pop     = w_valid & evt.EVT_READY;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;
  assign w_ovf_clr = w_ss_rise & r_armed & (r_cmd == c_CMD_STATUS) & (r_bitcnt >= 8'd16);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s  <= '0;
      r_ss_s   <= '0;
      r_mosi_s <= '0;
      r_sclk_d <= 1'b0;
      r_ss_d   <= 1'b0;
      r_armed  <= 1'b0;
      r_bitcnt <= 8'd0;
      r_sr     <= 7'd0;
      r_cmd    <= 8'd0;
      r_but_sw <= 8'd0;
      r_mb     <= 3'd0;
      r_miso   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_clk_s  <= {r_clk_s[SYNC_STAGES-2:0], SPI_CLK};
      r_ss_s   <= {r_ss_s[SYNC_STAGES-2:0], SPI_SS_IO};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], SPI_MOSI};
      r_sclk_d <= w_sclk;
      r_ss_d   <= w_ss;
      if (w_ss)
        r_armed <= 1'b1;
      if (w_ss)
        r_bitcnt <= 8'd0;
      else if (w_shift && r_bitcnt != 8'hFF)
        r_bitcnt <= r_bitcnt + 8'd1;
      if (w_shift)
        r_sr <= w_byte[6:0];
      if (w_bdone && w_bidx == 5'd0)
        r_cmd <= w_byte;
      if (w_bdone && w_bidx == 5'd1 && r_cmd == c_CMD_BUT)
        r_but_sw <= w_byte;
      if (w_bdone && w_bidx == 5'd3 && r_cmd == c_CMD_MOUSE)
        r_mb <= w_byte[2:0];
      if (w_active && w_fall)
        r_miso <= w_miso_bit;
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  // Joystick bytes are staged and only committed when the last one lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stage <= '0;
      r_joy   <= '0;
    end else if (w_bdone && w_joy_ok && w_bidx != 5'd0 && w_bidx <= c_JB) begin
      for (int j = 0; j < JOY_BYTES; j++)
        if (w_bidx == 5'(j + 1))
          r_stage[8*j +: 8] <= w_byte;
      if (w_bidx == c_JB)
        for (int n = 0; n < NJOY; n++)
          if (w_joy_idx == 2'(n))
            r_joy[n*c_JW +: c_JW] <= w_joy_new;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr)
        r_wp <= r_wp + c_AW'(1);
      if (w_pop)
        r_rp <= r_rp + c_AW'(1);
      if (w_wr && !w_pop)
        r_cnt <= r_cnt + c_CW'(1);
      else if (!w_wr && w_pop)
        r_cnt <= r_cnt - c_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wp] <= w_push_data;
  end

  assign SPI_MISO         = r_miso;
  assign JOY              = r_joy;
  assign BUTTONS          = r_but_sw[1:0];
  assign SWITCHES         = r_but_sw[3:2];
  assign CONF             = r_but_sw[7:4];
  assign MOUSE_BUTTONS    = r_mb;
  assign evt.EVT_VALID    = w_valid;
  assign evt.EVT_TYPE     = w_valid ? r_mem[r_rp][9:8] : 2'd0;
  assign evt.EVT_DATA     = w_valid ? r_mem[r_rp][7:0] : 8'd0;
  assign evt.EVT_OVERFLOW = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_user_io_evq.sv
`default_nettype none
// ============================================================================
// tb_user_io_evq : bench for user_io_evq (NJOY=4, JOY_BYTES=2, FIFO_DEPTH=8)
// Revision 1.0
// ============================================================================

module tb_user_io_evq;
  localparam int NJOY = 4, JB = 2, DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n, SPI_CLK, SPI_SS_IO, SPI_MOSI, SPI_MISO;
  logic [7:0]  CORE_TYPE = 8'hA4;
  logic [63:0] JOY;
  logic [1:0]  BUTTONS, SWITCHES;
  logic [3:0]  CONF;
  logic [2:0]  MOUSE_BUTTONS;

  user_io_evq_if evq ();

  user_io_evq #(.NJOY(NJOY), .JOY_BYTES(JB), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .SPI_CLK(SPI_CLK), .SPI_SS_IO(SPI_SS_IO),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .CORE_TYPE(CORE_TYPE), .JOY(JOY),
    .BUTTONS(BUTTONS), .SWITCHES(SWITCHES), .CONF(CONF),
    .MOUSE_BUTTONS(MOUSE_BUTTONS), .evt(evq)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  logic [7:0] tx [8];
  logic [7:0] rx [8];

  // Reference state: what the host has told the core so far.
  logic [7:0]  m_bs;
  logic [15:0] m_joy [4];
  logic [2:0]  m_mb;
  logic        m_ovf;
  logic [9:0]  m_q [$];

  typedef struct {
    int          n;
    logic [7:0]  b0, b1, b2, b3;
    logic [7:0]  e_bs;
    logic [2:0]  e_mb;
    logic [15:0] e_joy3;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_bs = 0; m_mb = 0; m_ovf = 0; m_q.delete();
    for (int i = 0; i < 4; i++) m_joy[i] = 0;
  endtask

  task automatic mpush(input logic [1:0] t, input logic [7:0] d);
    if (m_q.size() < DEPTH) m_q.push_back({t, d});
    else m_ovf = 1'b1;
  endtask

  task automatic model_frame(input int n);
    case (tx[0])
      8'h01: if (n >= 2) m_bs = tx[1];
      8'h02, 8'h03, 8'h10, 8'h11: begin
        int idx;
        idx = (tx[0] == 8'h02) ? 0 : (tx[0] == 8'h03) ? 1 : (tx[0] == 8'h10) ? 2 : 3;
        if (idx < NJOY && n >= 1 + JB) m_joy[idx] = {tx[2], tx[1]};
      end
      8'h04: begin
        if (n >= 2) mpush(2'd0, tx[1]);
        if (n >= 3) mpush(2'd1, tx[2]);
        if (n >= 4) m_mb = tx[3][2:0];
      end
      8'h05: if (n >= 2) mpush(2'd2, tx[1]);
      8'h06: if (n >= 2) mpush(2'd3, tx[1]);
      8'h07: if (n >= 2) m_ovf = 1'b0;
      default: ;
    endcase
  endtask

  // SPI mode 3: clock idles high, core shifts on fall, samples on rise.
  task automatic spi_frame(input int n, input int pop_bit, input int rst_bit);
    SPI_SS_IO = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        int bit_no;
        bit_no = k * 8 + (7 - i);
        SPI_CLK  = 1'b0;
        SPI_MOSI = tx[k][i];
        if (bit_no == rst_bit) begin
          reset_n = 1'b0;
          repeat (2) @(negedge clk);
          reset_n = 1'b1;
          repeat (4) @(negedge clk);
        end else begin
          repeat (6) @(negedge clk);
        end
        rx[k][i] = SPI_MISO;
        SPI_CLK  = 1'b1;
        if (bit_no == pop_bit) begin
          // Lands the pop on the same clock the byte's push is written.
          repeat (2) @(negedge clk);
          evq.EVT_READY = 1'b1;
          @(negedge clk);
          evq.EVT_READY = 1'b0;
          repeat (3) @(negedge clk);
        end else begin
          repeat (6) @(negedge clk);
        end
      end
    end
    SPI_SS_IO = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":but_sw"}, {CONF, SWITCHES, BUTTONS}, m_bs);
    chk({tag, ":joy"}, JOY, {m_joy[3], m_joy[2], m_joy[1], m_joy[0]});
    chk({tag, ":mouse_btn"}, MOUSE_BUTTONS, m_mb);
    chk({tag, ":overflow"}, evq.EVT_OVERFLOW, m_ovf);
    chk({tag, ":valid"}, evq.EVT_VALID, m_q.size() != 0);
    if (m_q.size() != 0) chk({tag, ":head"}, {evq.EVT_TYPE, evq.EVT_DATA}, m_q[0]);
  endtask

  task automatic drain();
    @(negedge clk);
    evq.EVT_READY = 1'b1;
    for (int i = 0; i < DEPTH + 2 && m_q.size() > 0; i++) begin
      chk("drain_valid", evq.EVT_VALID, 1);
      chk("drain_head", {evq.EVT_TYPE, evq.EVT_DATA}, m_q[0]);
      void'(m_q.pop_front());
      @(negedge clk);
    end
    evq.EVT_READY = 1'b0;
    @(negedge clk);
    chk("drain_empty", evq.EVT_VALID, 0);
  endtask

  task automatic status_read(input string tag);
    logic [7:0] exp;
    exp = {m_ovf, 2'b00, 5'(m_q.size())};
    tx[0] = 8'h07; tx[1] = 8'h00;
    spi_frame(2, -1, -1);
    m_ovf = 1'b0;
    chk({tag, ":status"}, rx[1], exp);
    chk({tag, ":ovf_after_status"}, evq.EVT_OVERFLOW, 0);
  endtask

  initial begin
    reset_n = 1'b0; SPI_CLK = 1'b1; SPI_SS_IO = 1'b1; SPI_MOSI = 1'b0;
    evq.EVT_READY = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    chk("rst_all", {JOY, BUTTONS, SWITCHES, CONF, MOUSE_BUTTONS}, 0);
    chk("rst_evt", {evq.EVT_VALID, evq.EVT_TYPE, evq.EVT_DATA, evq.EVT_OVERFLOW, SPI_MISO}, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    vt[0] = '{2, 8'h01, 8'hA5, 8'h00, 8'h00, 8'hA5, 3'd0, 16'h0000};
    vt[1] = '{3, 8'h11, 8'h34, 8'h12, 8'h00, 8'hA5, 3'd0, 16'h1234};
    vt[2] = '{2, 8'h11, 8'h56, 8'h00, 8'h00, 8'hA5, 3'd0, 16'h1234};
    vt[3] = '{4, 8'h04, 8'h05, 8'hFB, 8'h03, 8'hA5, 3'd3, 16'h1234};
    vt[4] = '{2, 8'h01, 8'h3C, 8'h00, 8'h00, 8'h3C, 3'd3, 16'h1234};
    vt[5] = '{3, 8'h10, 8'hAA, 8'hBB, 8'h00, 8'h3C, 3'd3, 16'h1234};
    vt[6] = '{2, 8'h09, 8'hFF, 8'h00, 8'h00, 8'h3C, 3'd3, 16'h1234};
    vt[7] = '{3, 8'h04, 8'h01, 8'h02, 8'h00, 8'h3C, 3'd3, 16'h1234};
    for (int v = 0; v < 8; v++) begin
      tx[0] = vt[v].b0; tx[1] = vt[v].b1; tx[2] = vt[v].b2; tx[3] = vt[v].b3;
      spi_frame(vt[v].n, -1, -1);
      model_frame(vt[v].n);
      chk($sformatf("vec%0d:but_sw", v), {CONF, SWITCHES, BUTTONS}, vt[v].e_bs);
      chk($sformatf("vec%0d:mouse_btn", v), MOUSE_BUTTONS, vt[v].e_mb);
      chk($sformatf("vec%0d:joy3", v), JOY[63:48], vt[v].e_joy3);
      chk($sformatf("vec%0d:miso_b0", v), rx[0], 8'hA4);
      check_outputs($sformatf("vec%0d", v));
    end
    chk("joy2_const", JOY[47:32], 16'hBBAA);
    chk("head_const", {evq.EVT_TYPE, evq.EVT_DATA}, 10'h005);
    drain();

    // Overflow: nine keycodes into an eight-deep FIFO with no consumer.
    for (int i = 0; i < 9; i++) begin
      tx[0] = 8'h05; tx[1] = 8'(8'h20 + i);
      spi_frame(2, -1, -1);
      model_frame(2);
    end
    check_outputs("ovf_fill");
    chk("ovf_set", evq.EVT_OVERFLOW, 1);
    tx[0] = 8'h07;
    spi_frame(1, -1, -1);
    chk("ovf_short_status_keeps", evq.EVT_OVERFLOW, 1);
    status_read("ovf");
    chk("status_088_const", rx[1], 8'h88);

    // Full FIFO with push and pop on the same clock.
    tx[0] = 8'h05; tx[1] = 8'h77;
    spi_frame(2, 15, -1);
    void'(m_q.pop_front());
    m_q.push_back({2'd2, 8'h77});
    check_outputs("full_pushpop");
    status_read("full_pushpop");
    chk("status_008_const", rx[1], 8'h08);
    drain();

    for (int r = 0; r < 40; r++) begin
      logic [7:0] cmds [9];
      int n;
      cmds = '{8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h04, 8'h05, 8'h06, 8'h09};
      tx[0] = cmds[$urandom_range(0, 8)];
      for (int b = 1; b < 4; b++) tx[b] = 8'($urandom);
      n = $urandom_range(1, 4);
      spi_frame(n, -1, -1);
      model_frame(n);
      check_outputs($sformatf("rnd%0d", r));
      if (r % 4 == 3) begin
        status_read($sformatf("rnd%0d", r));
        drain();
      end
    end

    // Reset asserted mid-frame right after the keycode command byte.
    tx[0] = 8'h05; tx[1] = 8'h5A;
    spi_frame(2, -1, 10);
    model_reset();
    check_outputs("midrst");
    chk("midrst_all", {JOY, BUTTONS, SWITCHES, CONF, MOUSE_BUTTONS, SPI_MISO}, 0);
    chk("midrst_evt", {evq.EVT_TYPE, evq.EVT_DATA}, 0);
    tx[0] = 8'h01; tx[1] = 8'hA5;
    spi_frame(2, -1, -1);
    model_frame(2);
    check_outputs("postrst");
    chk("postrst_btn", {CONF, SWITCHES, BUTTONS}, 8'hA5);
    chk("postrst_miso_b0", rx[0], 8'hA4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
